axis_pipeline: RTL

- DEPTH-stage elastic AXI-Stream register pipeline with full backpressure support.
- Used to break long timing paths between the RGMII/PCAP stream blocks while still honouring tready.
- This is the flow-controlled counterpart of the free-running delay-line pipeline: the downstream end can stall, and no beat is dropped or duplicated.
- Each stage is a full-throughput skid buffer, so all ready paths are registered.

---
 rtl/axis_pipeline.sv | 121 ++++++++++++
 1 files changed

// File: rtl/axis_pipeline.sv
// DEPTH-stage elastic AXI-Stream register pipeline; every stage is a full-throughput skid buffer.
// Optional tuser sideband is carried when AXIS_PIPELINE_USER_EN is defined.
module axis_pipeline #(
  parameter int DEPTH      = 2,
  parameter int DATA_WIDTH = 8,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int USER_WIDTH = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
`ifdef AXIS_PIPELINE_USER_EN
  input  logic [USER_WIDTH-1:0] s_axis_tuser,
`endif
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
`ifdef AXIS_PIPELINE_USER_EN
  output logic [USER_WIDTH-1:0] m_axis_tuser,
`endif
  input  logic                  m_axis_tready
);

`ifdef AXIS_PIPELINE_USER_EN
  localparam int UW = USER_WIDTH;
`else
  localparam int UW = 0;
`endif
  localparam int PW = DATA_WIDTH + KEEP_WIDTH + 1 + UW;

  if (DEPTH < 1) begin : g_depth_chk
    $fatal(1, "axis_pipeline: DEPTH must be at least 1");
  end
  if (DATA_WIDTH % 8 != 0) begin : g_width_chk
    $error("axis_pipeline: DATA_WIDTH must be a multiple of 8");
  end
  if (USER_WIDTH < 1) begin : g_user_chk
    $error("axis_pipeline: USER_WIDTH must be at least 1");
  end

  // Link k sits between stage k-1 and stage k; link 0 is s_axis, link DEPTH is m_axis.
  logic          valid_chain [DEPTH+1];
  logic          ready_chain [DEPTH+1];
  logic [PW-1:0] pay_chain   [DEPTH+1];

  assign valid_chain[0]     = s_axis_tvalid;
  assign ready_chain[DEPTH] = m_axis_tready;
  assign s_axis_tready      = ready_chain[0];
  assign m_axis_tvalid      = valid_chain[DEPTH];

`ifdef AXIS_PIPELINE_USER_EN
  assign pay_chain[0] = {s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tuser};
  assign {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser} = pay_chain[DEPTH];
`else
  assign pay_chain[0] = {s_axis_tdata, s_axis_tkeep, s_axis_tlast};
  assign {m_axis_tdata, m_axis_tkeep, m_axis_tlast} = pay_chain[DEPTH];
`endif

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic          out_valid;
    logic          skid_valid;
    logic          skid_valid_next;
    logic          ready_reg;
    logic [PW-1:0] out_payload;
    logic [PW-1:0] skid_payload;
    logic          in_xfer;
    logic          out_xfer;

    assign in_xfer  = valid_chain[k] && ready_reg;
    assign out_xfer = out_valid && ready_chain[k+1];

    always_comb begin
      skid_valid_next = skid_valid;
      if (!out_valid || out_xfer) begin
        skid_valid_next = skid_valid && in_xfer;
      end else if (in_xfer) begin
        skid_valid_next = 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        out_valid    <= 1'b0;
        skid_valid   <= 1'b0;
        ready_reg    <= 1'b0;
        out_payload  <= '0;
        skid_payload <= '0;
      end else begin
        skid_valid <= skid_valid_next;
        // Ready is registered from the next skid state, so upstream never sees downstream ready combinationally.
        ready_reg  <= !skid_valid_next;
        if (!out_valid || out_xfer) begin
          if (skid_valid) begin
            out_valid   <= 1'b1;
            out_payload <= skid_payload;
            if (in_xfer) begin
              skid_payload <= pay_chain[k];
            end
          end else begin
            out_valid <= in_xfer;
            if (in_xfer) begin
              out_payload <= pay_chain[k];
            end
          end
        end else if (in_xfer) begin
          skid_payload <= pay_chain[k];
        end
      end
    end

    assign valid_chain[k+1] = out_valid;
    assign pay_chain[k+1]   = out_payload;
    assign ready_chain[k]   = ready_reg;
  end

endmodule
